// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer:
// op codes, register mode codes and the FSM state type.
package shift_seq_ctrl_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake bundle: valid/ready plus op, count, data, fill.
// master drives the command, slave (the sequencer) returns ready.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt,
    output cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt,
    input  cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl_step_cnt.sv
// shift_step_cnt: CNT_W down-counter with load, decrement and a
// last-step flag (count of 0 or 1 means this edge ends the op).
module shift_step_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = val_i;
    else if (dec_i)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q <= CNT_W'(1));
endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an 8-bit bidirectional shift register (mode,
// serial fills, parallel data) one command per valid/ready handshake.
// Ports: CP/NCR clock and async low reset, cmd handshake interface,
// q_in register feedback, S1/S0/SL/SR/D register controls, done pulse.
// Macro SHIFT_SEQ_ROTATE_EN enables op 11 as rotate-right; otherwise
// op 11 is a no-op that still pulses done.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             NCR,
  shift_seq_ctrl_if.slave  cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic             S1,
  output logic             S0,
  output logic             SL,
  output logic             SR,
  output logic [WIDTH-1:0] D,
  output logic             done
);
  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             sl_q, sl_d;
  logic             sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             done_q, done_d;
  logic             cnt_ld, cnt_dec, last;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign cnt_zero = (cmd.cmd_cnt == '0);

  shift_step_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (CP),
    .rst_ni (NCR),
    .ld_i   (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .last_o (last)
  );

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q, rot_d;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    d_d     = d_q;
    done_d  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = cmd.cmd_cnt;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = ST_EXEC;
          cnt_ld  = 1'b1;
          sl_d    = 1'b0;
          sr_d    = 1'b0;
          unique case (1'b1)
            cmd.cmd_op == OP_LOAD: begin
              mode_d  = MODE_LOAD;
              d_d     = cmd.cmd_data;
              cnt_val = '0;
            end
            cmd.cmd_op == OP_SHR: begin
              mode_d = cnt_zero ? MODE_HOLD : MODE_RIGHT;
              sr_d   = cmd.cmd_fill;
            end
            cmd.cmd_op == OP_SHL: begin
              mode_d = cnt_zero ? MODE_HOLD : MODE_LEFT;
              sl_d   = cmd.cmd_fill;
            end
            default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
              mode_d = cnt_zero ? MODE_HOLD : MODE_RIGHT;
              rot_d  = 1'b1;
`else
              mode_d  = MODE_HOLD;
              cnt_val = '0;
`endif
            end
          endcase
        end
      end
      state_q == ST_EXEC: begin
        if (last) begin
          state_d = ST_DONE;
          mode_d  = MODE_HOLD;
          done_d  = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = 1'b0;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      state_q == ST_DONE: state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge NCR) begin
    if (!NCR) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      done_q  <= done_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign S1   = mode_q[1];
  assign S0   = mode_q[0];
  assign SL   = sl_q;
  assign D    = d_q;
  assign done = done_q;

  // Rotation feeds the current LSB back in as the MSB fill.
`ifdef SHIFT_SEQ_ROTATE_EN
  assign SR = rot_q ? q_in[0] : sr_q;
`else
  assign SR = sr_q;
`endif
endmodule
